// File: rtl/abr_params_pkg.sv
// Shared ML-DSA parameters and the w1Encode controller state type.
// Also holds a small width helper used for the counter sizing.
package abr_params_pkg;

  localparam int MLDSA_N = 256;
  localparam int MLDSA_K = 8;
  localparam int W1_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } w1enc_state_e;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/decompose_w1encode_fifo.sv
// Two-entry synchronous FIFO holding packed words plus their poly-last flag.
// Reset and zeroize both clear the storage so a cleared FIFO presents all zeros.
module decompose_w1encode_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             zeroize,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       cnt_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests so an overfull push or empty pop can never corrupt state.
  always_comb begin
    push_s = push & (cnt_r != 2'd2);
    pop_s  = pop & (cnt_r != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (cnt_r == 2'd2);
  assign empty = (cnt_r == 2'd0);
  assign cnt   = cnt_r;

endmodule

// File: rtl/decompose_w1encode.sv
// ML-DSA w1Encode: packs 4-bit w1 coefficients LSB-first into OUT_WIDTH-bit words
// and streams them through a 2-entry FIFO toward the SHAKE message path.
module decompose_w1encode
  import abr_params_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int OUT_WIDTH      = 64,
  parameter int COEFF_PER_POLY = MLDSA_N,
  parameter int NUM_POLY       = MLDSA_K
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           zeroize,
  input  logic                           start_i,
  input  logic                           w1_valid_i,
  input  logic [W1_BITS*NUM_LANES-1:0]   w1_i,
  output logic                           w1_ready_o,
  output logic [OUT_WIDTH-1:0]           data_o,
  output logic                           data_valid_o,
  input  logic                           data_ready_i,
  output logic                           poly_last_o,
  output logic                           done_o,
  output logic                           overflow_o
);

  localparam int LANE_W = W1_BITS * NUM_LANES;
  localparam int BPW    = OUT_WIDTH / LANE_W;
  localparam int WPP    = COEFF_PER_POLY * W1_BITS / OUT_WIDTH;
  localparam int BEAT_W = clog2_min1(BPW);
  localparam int WORD_W = clog2_min1(WPP);
  localparam int POLY_W = clog2_min1(NUM_POLY);

  w1enc_state_e          state_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [WORD_W-1:0]     word_cnt_r;
  logic [POLY_W-1:0]     poly_cnt_r;
  logic [OUT_WIDTH-1:0]  acc_r;
  logic                  overflow_r;
  logic                  done_r;

  logic                  w1_ready_s;
  logic                  beat_acc_s;
  logic                  word_end_s;
  logic                  poly_end_s;
  logic                  run_end_s;
  logic                  push_s;
  logic                  pop_s;
  logic [OUT_WIDTH-1:0]  word_s;
  logic [OUT_WIDTH:0]    fifo_rdata_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [1:0]            fifo_cnt_s;

  // Handshake qualifiers and the word image including the beat being accepted.
  always_comb begin
    w1_ready_s = (state_r == PACK) & ~fifo_full_s;
    beat_acc_s = w1_valid_i & w1_ready_s;
    word_end_s = (beat_cnt_r == BEAT_W'(BPW - 1));
    poly_end_s = (word_cnt_r == WORD_W'(WPP - 1));
    run_end_s  = word_end_s & poly_end_s & (poly_cnt_r == POLY_W'(NUM_POLY - 1));
    push_s     = beat_acc_s & word_end_s;
    pop_s      = ~fifo_empty_s & data_ready_i;
    word_s     = acc_r;
    word_s[int'(beat_cnt_r) * LANE_W +: LANE_W] = w1_i;
  end

  // Controller FSM with counters, accumulator and registered status flags.
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      word_cnt_r <= '0;
      poly_cnt_r <= '0;
      acc_r      <= '0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r    <= PACK;
            overflow_r <= 1'b0;
          end
        end
        PACK: begin
          if (w1_valid_i && !w1_ready_s) begin
            overflow_r <= 1'b1;
          end
          if (beat_acc_s) begin
            acc_r <= word_s;
            if (word_end_s) begin
              beat_cnt_r <= '0;
              if (poly_end_s) begin
                word_cnt_r <= '0;
                if (run_end_s) begin
                  poly_cnt_r <= '0;
                  state_r    <= DRAIN;
                end else begin
                  poly_cnt_r <= poly_cnt_r + POLY_W'(1);
                end
              end else begin
                word_cnt_r <= word_cnt_r + WORD_W'(1);
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
          end
        end
        DRAIN: begin
          // Nothing is pushed here, so popping the sole entry empties the FIFO.
          if (pop_s && (fifo_cnt_s == 2'd1)) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  decompose_w1encode_fifo #(
    .WIDTH (OUT_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .zeroize (zeroize),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   ({poly_end_s, word_s}),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .cnt     (fifo_cnt_s)
  );

  assign w1_ready_o   = w1_ready_s;
  assign data_o       = fifo_rdata_s[OUT_WIDTH-1:0];
  assign poly_last_o  = fifo_rdata_s[OUT_WIDTH];
  assign data_valid_o = ~fifo_empty_s;
  assign done_o       = done_r;
  assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_decompose_w1encode.sv
// Scoreboard bench for decompose_w1encode: beats build expected words in a queue,
// a negedge monitor pops and compares every word the DUT hands downstream.
module tb_decompose_w1encode;

  logic        clk = 1'b0;
  logic        reset, zeroize, start_i, w1_valid_i, data_ready_i;
  logic [15:0] w1_i;
  logic        w1_ready_o, data_valid_o, poly_last_o, done_o, overflow_o;
  logic [63:0] data_o;

  int checks = 0;
  int fails  = 0;
  logic [64:0] sb [$];
  logic [63:0] part_word;
  int part_beats, word_idx, pops, lasts, done_cnt;
  logic        held;
  logic [64:0] held_val;

  decompose_w1encode dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .w1_valid_i(w1_valid_i), .w1_i(w1_i), .w1_ready_o(w1_ready_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .poly_last_o(poly_last_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare popped words, check hold stability, count done pulses.
  always @(negedge clk) begin
    if (data_valid_o) begin
      if (held) begin
        checks++;
        if ({poly_last_o, data_o} !== held_val) begin
          fails++;
          $display("FAIL hold: got %h expected %h", {poly_last_o, data_o}, held_val);
        end
      end
      if (data_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: got word %h expected none", data_o);
        end else begin
          logic [64:0] exp;
          exp = sb.pop_front();
          if ({poly_last_o, data_o} !== exp) begin
            fails++;
            $display("FAIL word%0d: got %h expected %h", pops, {poly_last_o, data_o}, exp);
          end
        end
        pops++;
        if (poly_last_o) lasts++;
        held = 1'b0;
      end else begin
        held     = 1'b1;
        held_val = {poly_last_o, data_o};
      end
    end else begin
      held = 1'b0;
    end
    if (done_o) done_cnt++;
  end

  function automatic logic [15:0] beat_val(input int run, input int i);
    logic [15:0] v;
    if (run == 1) begin
      case (i)
        0:       v = 16'h3210;
        1:       v = 16'h7654;
        2:       v = 16'hBA98;
        3:       v = 16'hFEDC;
        default: v = 16'h3210;
      endcase
    end else begin
      v = 16'(i * 37 + run * 4099) ^ 16'hA5C3;
    end
    return v;
  endfunction

  task automatic model_beat(input logic [15:0] v);
    part_word[part_beats*16 +: 16] = v;
    part_beats++;
    if (part_beats == 4) begin
      sb.push_back({((word_idx % 16) == 15) ? 1'b1 : 1'b0, part_word});
      word_idx++;
      part_beats = 0;
    end
  endtask

  // Drive one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [15:0] v);
    int n = 0;
    w1_valid_i = 1'b1;
    w1_i       = v;
    @(negedge clk);
    while (!w1_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!w1_ready_o) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got ready 0 expected 1");
    end else begin
      model_beat(v);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_beats(input int run, input int from, input int to);
    for (int i = from; i <= to; i++) send_beat(beat_val(run, i));
    w1_valid_i = 1'b0;
  endtask

  task automatic do_start();
    part_beats = 0;
    word_idx   = 0;
    pops       = 0;
    lasts      = 0;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base = done_cnt;
    for (int n = 0; n < 100 && done_cnt == base; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, 64'(done_cnt - base), 64'd1);
    check({name, "_pops"}, 64'(pops), 64'd128);
    check({name, "_poly_last"}, 64'(lasts), 64'd8);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_idle_ready"}, 64'(w1_ready_o), 64'd0);
    check({name, "_idle_valid"}, 64'(data_valid_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int dbase;
    reset = 1'b1; zeroize = 1'b0; start_i = 1'b0; w1_valid_i = 1'b0;
    w1_i = 16'h0; data_ready_i = 1'b0; held = 1'b0; held_val = '0;
    part_word = '0; part_beats = 0; word_idx = 0; pops = 0; lasts = 0; done_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(w1_ready_o), 64'd0);
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_last", 64'(poly_last_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    @(posedge clk); #1;

    // Run 1: first word hand-checked for value and one-cycle latency, then a full run.
    data_ready_i = 1'b1;
    do_start();
    run_beats(1, 0, 3);
    @(negedge clk);
    check("t1_latency_valid", 64'(data_valid_o), 64'd1);
    check("t1_word", data_o, 64'hFEDCBA9876543210);
    @(posedge clk); #1;
    run_beats(1, 4, 511);
    wait_done("run1");

    // Run 2: downstream stalled until the FIFO fills, overflow while held off.
    data_ready_i = 1'b0;
    do_start();
    run_beats(2, 0, 7);
    w1_valid_i = 1'b1;
    w1_i = beat_val(2, 8);
    @(negedge clk);
    check("t3_full_ready", 64'(w1_ready_o), 64'd0);
    check("t3_full_valid", 64'(data_valid_o), 64'd1);
    repeat (2) @(negedge clk);
    check("t4_overflow_set", 64'(overflow_o), 64'd1);
    @(posedge clk); #1;
    data_ready_i = 1'b1;
    run_beats(2, 8, 511);
    wait_done("run2");
    check("t4_overflow_sticky", 64'(overflow_o), 64'd1);

    // Run 3: zeroize in the middle of word 5.
    do_start();
    @(negedge clk);
    check("t4_overflow_cleared", 64'(overflow_o), 64'd0);
    @(posedge clk); #1;
    run_beats(3, 0, 21);
    repeat (4) @(posedge clk);
    #1;
    check("t5_sb_drained", 64'(sb.size()), 64'd0);
    dbase = done_cnt;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    check("t5_z_ready", 64'(w1_ready_o), 64'd0);
    check("t5_z_valid", 64'(data_valid_o), 64'd0);
    check("t5_z_data", data_o, 64'd0);
    check("t5_z_last", 64'(poly_last_o), 64'd0);
    check("t5_z_ovf", 64'(overflow_o), 64'd0);
    repeat (3) @(negedge clk);
    check("t5_no_done", 64'(done_cnt - dbase), 64'd0);
    @(posedge clk); #1;

    // Run 4: clean restart, simultaneous push/pop at occupancy 1, ignored start.
    data_ready_i = 1'b0;
    do_start();
    run_beats(4, 0, 6);
    data_ready_i = 1'b1;
    send_beat(beat_val(4, 7));
    w1_valid_i   = 1'b0;
    data_ready_i = 1'b0;
    @(negedge clk);
    check("t6_cnt1_ready", 64'(w1_ready_o), 64'd1);
    check("t6_cnt1_valid", 64'(data_valid_o), 64'd1);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("t6_start_ignored", 64'(w1_ready_o), 64'd1);
    @(posedge clk); #1;
    data_ready_i = 1'b1;
    run_beats(4, 8, 511);
    wait_done("run4");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
